// File: rtl/nn_pkg.sv
// Shared types and defaults for the NN batch sequencer.
package nn_pkg;

    localparam int LABEL_W             = 8;
    localparam int NUM_SAMPLES_DEFAULT = 750;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT    = 3'd2,
        COMPARE = 3'd3,
        NEXT    = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } seq_state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Loadable down-counter: clr loads the limit, en counts down, expired flags zero.
module seq_watchdog #(
    parameter int CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] r_cnt;

    // Loading CYCLES-1 makes expired true on the CYCLES-th enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= CW'(CYCLES - 1);
        end else if (en && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expired = (r_cnt == '0);

endmodule

// File: rtl/nn_batch_sequencer.sv
// Runs the NN core over the stored test set and keeps total/correct counts.
// Define SEQ_TIMEOUT_EN to add a WAIT watchdog and the ERR state.
module nn_batch_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_SAMPLES    = nn_pkg::NUM_SAMPLES_DEFAULT,
    parameter int IDX_W          = 10,
    parameter int LABEL_W        = nn_pkg::LABEL_W,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    output logic               nn_start,
    input  logic               nn_batch_done,
    input  logic [LABEL_W-1:0] nn_result,
    output logic [IDX_W-1:0]   lbl_addr,
    input  logic [LABEL_W-1:0] lbl_data,
    output logic [IDX_W-1:0]   total_count,
    output logic [IDX_W-1:0]   correct_count,
    output logic               busy,
    output logic               finished,
    output logic               error
);

    seq_state_e         r_state;
    seq_state_e         w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_total;
    logic [IDX_W-1:0]   r_correct;
    logic [LABEL_W-1:0] r_result;
    logic               r_done_prev;
    logic               r_start;
    logic               r_busy;
    logic               r_finished;
    logic               w_rise;
    logic               w_last;
    logic               w_go_accept;
    logic               w_expired;

    assign w_rise      = nn_batch_done & ~r_done_prev;
    assign w_last      = (r_idx == IDX_W'(NUM_SAMPLES - 1));
    assign w_go_accept = go & (r_state == IDLE || r_state == DONE || r_state == ERR);

`ifdef SEQ_TIMEOUT_EN
    logic r_error;

    seq_watchdog #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (r_state == START),
        .en      (r_state == WAIT),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_error <= 1'b0;
        else      r_error <= (w_next == ERR);
    end

    assign error = r_error;
`else
    assign w_expired = 1'b0;
    assign error     = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (go) w_next = START;
            START:      w_next = WAIT;
            // A rising edge wins over an expiry landing on the same cycle.
            WAIT: begin
                if (w_rise)         w_next = COMPARE;
                else if (w_expired) w_next = ERR;
            end
            COMPARE:    w_next = NEXT;
            NEXT:       w_next = w_last ? DONE : START;
`ifdef SEQ_TIMEOUT_EN
            ERR:        if (go) w_next = START;
`endif
            default:    w_next = IDLE;
        endcase
    end

    // Status outputs are registered off the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_total     <= '0;
            r_correct   <= '0;
            r_result    <= '0;
            r_done_prev <= 1'b0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_finished  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_done_prev <= nn_batch_done;
            r_start     <= (w_next == START);
            r_busy      <= (w_next inside {START, WAIT, COMPARE, NEXT});
            r_finished  <= (w_next == DONE);
            if (w_go_accept) begin
                r_idx     <= '0;
                r_total   <= '0;
                r_correct <= '0;
            end
            if (r_state == WAIT && w_rise) r_result <= nn_result;
            if (r_state == COMPARE) begin
                r_total <= r_total + 1'b1;
                if (r_result == lbl_data) r_correct <= r_correct + 1'b1;
            end
            if (r_state == NEXT && !w_last) r_idx <= r_idx + 1'b1;
        end
    end

    assign nn_start      = r_start;
    assign lbl_addr      = r_idx;
    assign total_count   = r_total;
    assign correct_count = r_correct;
    assign busy          = r_busy;
    assign finished      = r_finished;

endmodule

// File: tb/tb_nn_batch_sequencer.sv
// Self-checking bench: behavioural core + label ROM, timeline model, per-cycle compare.
module tb_nn_batch_sequencer;

    localparam int N     = 4;
    localparam int IDX_W = 10;
    localparam int LW    = 8;
    localparam int TO    = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             go = 1'b0;
    logic             nn_batch_done = 1'b0;
    logic [LW-1:0]    nn_result = '0;
    logic [LW-1:0]    lbl_data = '0;
    logic             nn_start, busy, finished, error;
    logic [IDX_W-1:0] lbl_addr, total_count, correct_count;

    always #5 clk = ~clk;

    nn_batch_sequencer #(
        .NUM_SAMPLES    (N),
        .IDX_W          (IDX_W),
        .LABEL_W        (LW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .go            (go),
        .nn_start      (nn_start),
        .nn_batch_done (nn_batch_done),
        .nn_result     (nn_result),
        .lbl_addr      (lbl_addr),
        .lbl_data      (lbl_data),
        .total_count   (total_count),
        .correct_count (correct_count),
        .busy          (busy),
        .finished      (finished),
        .error         (error)
    );

    int checks = 0;
    int errors = 0;

    logic [LW-1:0] labels  [N];
    logic [LW-1:0] results [N];
    int  lat_cfg  = 20;
    bit  lat_rand = 0;
    bit  sticky   = 0;
    bit  skip_en  = 0;
    int  skip_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Label ROM, synchronous read with one cycle of latency.
    logic [IDX_W-1:0] rom_addr;
    initial forever begin
        @(negedge clk);
        rom_addr = lbl_addr;
        @(posedge clk);
        #1;
        lbl_data = labels[int'(rom_addr)];
    end

    // Behavioural core: answers lat cycles after seeing start; optional sticky done.
    initial forever begin
        @(posedge clk);
        #1;
        if (nn_start === 1'b1 && !(skip_en && int'(lbl_addr) == skip_idx)) begin
            int lat, si;
            si  = int'(lbl_addr);
            lat = lat_rand ? int'($urandom_range(1, 8)) : lat_cfg;
            repeat (lat) @(posedge clk);
            #1;
            if (nn_batch_done) begin
                nn_batch_done = 1'b0;
                @(posedge clk);
                #1;
            end
            nn_batch_done = 1'b1;
            nn_result     = results[si];
            if (!sticky) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
                nn_batch_done = 1'b0;
            end
        end
    end

    // Timeline model: edge numbers of the start pulse and the accepted response
    // determine every output of the following cycles.
    int  n = 0;
    bit  m_act, m_fin, m_err, m_prev;
    int  m_idx, m_tot, m_cor, m_start, m_resp;
    logic [LW-1:0] m_cap;
    bit  s_rst, s_go, s_done;
    logic [LW-1:0] s_res;
    int  n_starts = 0;
    int  last_resp = 0, fin_edge = 0;

    initial forever begin
        @(posedge clk);
        s_rst = rst; s_go = go; s_done = nn_batch_done; s_res = nn_result;
        n++;
        if (!s_rst) begin
            m_act = 0; m_fin = 0; m_err = 0; m_prev = 0;
            m_idx = 0; m_tot = 0; m_cor = 0; m_resp = -1; m_start = -10;
        end else begin
            if (!m_act) begin
                if (s_go) begin
                    m_act = 1; m_fin = 0; m_err = 0;
                    m_idx = 0; m_tot = 0; m_cor = 0; m_start = n; m_resp = -1;
                end
            end else if (m_resp < 0) begin
                if (n >= m_start + 2) begin
                    if (s_done && !m_prev) begin
                        m_resp = n; m_cap = s_res; last_resp = n;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (n == m_start + 1 + TO) begin
                        m_act = 0; m_err = 1;
                    end
`endif
                end
            end else if (n == m_resp + 1) begin
                m_tot++;
                if (m_cap == labels[m_idx]) m_cor++;
            end else if (n == m_resp + 2) begin
                if (m_idx == N - 1) begin
                    m_act = 0; m_fin = 1; fin_edge = n;
                end else begin
                    m_idx++; m_start = n; m_resp = -1;
                end
            end
            m_prev = s_done;
        end
        #1;
        chk("nn_start", nn_start, (m_act && m_resp < 0 && m_start == n));
        chk("busy", busy, m_act);
        chk("finished", finished, m_fin);
        chk("error", error, m_err);
        chk("lbl_addr", lbl_addr, m_idx);
        chk("total_count", total_count, m_tot);
        chk("correct_count", correct_count, m_cor);
        if (nn_start === 1'b1) n_starts++;
    end

    task automatic pulse_go();
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    // Waits for the model to leave the run; optionally pokes go while busy.
    task automatic wait_idle(input int max, input bit glitch);
        bit ok;
        ok = 0;
        for (int i = 0; i < max; i++) begin
            @(posedge clk);
            #2;
            if (!m_act) begin
                ok = 1;
                break;
            end
            go = glitch && busy && ($urandom_range(0, 5) == 0);
        end
        go = 1'b0;
        chk("run_completes", ok, 1);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < N; i++) begin
            labels[i] = '0; results[i] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_finished", finished, 0);
        chk("rst_total", total_count, 0);
        chk("rst_addr", lbl_addr, 0);
        chk("rst_start", nn_start, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed run: one mismatch on sample 1.
        labels  = '{8'd3, 8'd7, 8'd1, 8'd9};
        results = '{8'd3, 8'd2, 8'd1, 8'd9};
        lat_cfg = 20; n_starts = 0;
        pulse_go();
        wait_idle(400, 0);
        chk("t1_finished", finished, 1);
        chk("t1_total", total_count, 4);
        chk("t1_correct", correct_count, 3);
        chk("t1_starts", n_starts, 4);

        // Done held high across sample boundaries.
        sticky = 1; results = labels; n_starts = 0;
        pulse_go();
        wait_idle(400, 0);
        chk("t2_total", total_count, 4);
        chk("t2_correct", correct_count, 4);
        chk("t2_starts", n_starts, 4);

        // go while busy is ignored; go in DONE restarts immediately.
        sticky = 0; lat_cfg = 6; n_starts = 0;
        pulse_go();
        wait_idle(400, 1);
        chk("t3_starts", n_starts, 4);
        chk("t3_finished", finished, 1);
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        chk("t3_restart_start", nn_start, 1);
        chk("t3_restart_total", total_count, 0);
        chk("t3_restart_busy", busy, 1);
        wait_idle(400, 0);

        // Reset in the middle of WAIT on sample 2.
        lat_cfg = 20;
        pulse_go();
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (lbl_addr == 2 && busy && !nn_start) begin
                found = 1;
                break;
            end
        end
        chk("t4_reached_sample2", found, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("t4_busy", busy, 0);
        chk("t4_total", total_count, 0);
        chk("t4_correct", correct_count, 0);
        chk("t4_addr", lbl_addr, 0);
        rst = 1'b1;
        n_starts = 0;
        repeat (40) @(posedge clk);
        #2;
        chk("t4_no_start", n_starts, 0);

`ifdef SEQ_TIMEOUT_EN
        // Core never answers sample 1: watchdog drops to ERR with partial totals.
        lat_cfg = 3; skip_en = 1; skip_idx = 1;
        pulse_go();
        wait_idle(200, 0);
        chk("t5_error", error, 1);
        chk("t5_total", total_count, 1);
        chk("t5_busy", busy, 0);
        skip_en = 0;
        repeat (10) @(posedge clk);
        #1;
        pulse_go();
        wait_idle(400, 0);
        chk("t5_clean_error", error, 0);
        chk("t5_clean_total", total_count, 4);
`endif

        // Fastest core: DONE two edges after the accepted rising edge.
        lat_cfg = 1; results = labels;
        pulse_go();
        wait_idle(200, 0);
        chk("t6_fin_latency", fin_edge - last_resp, 2);
        chk("t6_correct", correct_count, 4);

        // Randomised runs.
        lat_rand = 1;
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) begin
                labels[i]  = LW'($urandom_range(0, 15));
                results[i] = ($urandom_range(0, 1) == 1) ? labels[i] : LW'($urandom_range(0, 15));
            end
            sticky = ($urandom_range(0, 1) == 1);
            repeat (4) @(posedge clk);
            #1;
            pulse_go();
            wait_idle(600, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
